// File: rtl/mux_arb_pkg.sv
// Shared constants, output-register states and the select-width helper for mux_arb_nw.
package mux_arb_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_e;

  // A single channel still needs a one-bit index.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N    = 8,
  parameter int unsigned SELW = 3
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] gnt_o,
  output logic            gnt_valid_o
);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic           found;
  int unsigned    pos;

  // Rotating a doubled copy puts channel ptr_i at bit 0, so a plain priority encode suffices.
  assign req2 = {req_i, req_i};
  assign rot  = N'(req2 >> ptr_i);

  always_comb begin
    found = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        pos   = i + int'(ptr_i);
        if (pos >= N) pos = pos - N;
      end
    end
    gnt_valid_o = found;
    gnt_o       = SELW'(pos);
  end

endmodule

// File: rtl/mux_arb_nw.sv
// N-input registered mux with direct-select or round-robin arbitration and
// valid/ready handshakes on every input and on the single output.
module mux_arb_nw
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 8,
  parameter int unsigned SELW  = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      s,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  ostate_e          state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [WIDTH-1:0] chan [N];
  logic             dir_valid;
  logic [SELW-1:0]  rr_idx;
  logic             rr_valid;
  logic [SELW-1:0]  grant_idx;
  logic             grant_valid;
  logic             can_load;
  logic             load;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      chan[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_pick (
    .req_i       (in_valid),
    .ptr_i       (ptr_q),
    .gnt_o       (rr_idx),
    .gnt_valid_o (rr_valid)
  );

  // Out-of-range selects (possible when N is not a power of two) never grant.
  always_comb begin
    dir_valid = 1'b0;
    if (int'(s) < N) dir_valid = in_valid[s];
  end

  always_comb begin
    if (mode == MODE_RR) begin
      grant_idx   = rr_idx;
      grant_valid = rr_valid;
    end else begin
      grant_idx   = s;
      grant_valid = dir_valid;
    end
  end

  assign can_load = (state_q == ST_EMPTY) || out_ready;
  assign load     = rst && can_load && grant_valid;

  always_comb begin
    in_ready = '0;
    if (load) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      state_d = ST_FULL;
      data_d  = chan[grant_idx];
      sel_d   = grant_idx;
      ptr_d   = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;
    end else if (state_q == ST_FULL && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux_arb_nw.sv
// Directed-vector bench for mux_arb_nw: default 8x16 instance plus a 10x8 instance.
module tb_mux_arb_nw;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default instance (N=8, WIDTH=16)
  logic [127:0] a_in_data;
  logic [7:0]   a_in_valid, a_in_ready;
  logic         a_mode, a_out_valid, a_out_ready;
  logic [2:0]   a_s, a_out_sel;
  logic [15:0]  a_out_data;

  // Non-power-of-two instance (N=10, WIDTH=8)
  logic [79:0]  b_in_data;
  logic [9:0]   b_in_valid, b_in_ready;
  logic         b_mode, b_out_valid, b_out_ready;
  logic [3:0]   b_s, b_out_sel;
  logic [7:0]   b_out_data;

  int n_vec = 0;
  int n_bad = 0;

  mux_arb_nw dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .mode      (a_mode),
    .s         (a_s),
    .out_data  (a_out_data),
    .out_sel   (a_out_sel),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
  );

  mux_arb_nw #(
    .WIDTH (8),
    .N     (10)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .mode      (b_mode),
    .s         (b_s),
    .out_data  (b_out_data),
    .out_sel   (b_out_sel),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] chan_a(input int i);
    return (i == 3) ? 16'hA5A5 : 16'hC000 + 16'(i);
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) a_in_data[i*16 +: 16] = chan_a(i);
    for (int i = 0; i < 10; i++) b_in_data[i*8 +: 8] = 8'h50 + 8'(i);
    a_in_valid = '0; a_mode = 1'b0; a_s = '0; a_out_ready = 1'b0;
    b_in_valid = '0; b_mode = 1'b0; b_s = '0; b_out_ready = 1'b0;

    // Reset and idle
    #3;
    a_in_valid = 8'hFF; a_s = 3'd3;
    #1;
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    a_in_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    // Direct select s=3
    a_mode = 1'b0; a_s = 3'd3; a_in_valid = 8'hFF; a_out_ready = 1'b1;
    #1;
    check("dir_in_ready", a_in_ready, 8'h08);
    tick();
    check("dir_out_data", a_out_data, 16'hA5A5);
    check("dir_out_sel", a_out_sel, 3);
    check("dir_out_valid", a_out_valid, 1);

    // Direct select with the selected channel idle: no grant
    a_in_valid = 8'hF7;
    #1;
    check("dir_idle_ready", a_in_ready, 0);
    a_in_valid = 8'hFF;

    // Asynchronous reset mid-cycle while FULL
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", a_out_valid, 0);
    check("arst_out_data", a_out_data, 0);
    check("arst_out_sel", a_out_sel, 0);
    check("arst_in_ready", a_in_ready, 0);
    a_in_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    // Round-robin wrap from ptr=0, full throughput
    a_mode = 1'b1; a_in_valid = 8'hFF; a_out_ready = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      check("rr_in_ready", a_in_ready, 32'(8'h01 << (i % 8)));
      tick();
      check("rr_out_sel", a_out_sel, i % 8);
      check("rr_out_data", a_out_data, chan_a(i % 8));
      check("rr_out_valid", a_out_valid, 1);
    end

    // Mode switch: last direct grant s=5, round-robin resumes at 6
    a_mode = 1'b0; a_s = 3'd5;
    tick();
    check("sw_dir_sel", a_out_sel, 5);
    a_mode = 1'b1;
    tick();
    check("sw_rr_sel", a_out_sel, 6);

    // Sparse round-robin from ptr=2
    a_mode = 1'b0; a_s = 3'd1;
    tick();
    check("sp_setup_sel", a_out_sel, 1);
    a_mode = 1'b1; a_in_valid = 8'b1000_0010;
    #1;
    check("sp_ready0", a_in_ready, 8'h80);
    tick();
    check("sp_sel0", a_out_sel, 7);
    check("sp_ready1", a_in_ready, 8'h02);
    tick();
    check("sp_sel1", a_out_sel, 1);
    check("sp_ready2", a_in_ready, 8'h80);
    tick();
    check("sp_sel2", a_out_sel, 7);

    // Backpressure: FULL with channel 7, ptr=0
    a_out_ready = 1'b0; a_in_valid = 8'hFF;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", a_in_ready, 0);
      tick();
      check("bp_out_data", a_out_data, chan_a(7));
      check("bp_out_valid", a_out_valid, 1);
    end
    a_out_ready = 1'b1;
    #1;
    check("bp_release_ready", a_in_ready, 8'h01);
    tick();
    check("bp_reload_sel", a_out_sel, 0);
    check("bp_reload_data", a_out_data, chan_a(0));
    check("bp_reload_valid", a_out_valid, 1);

    // Drain with no new grant: valid drops, data and sel hold
    a_in_valid = '0;
    #1;
    check("drain_in_ready", a_in_ready, 0);
    tick();
    check("drain_out_valid", a_out_valid, 0);
    check("drain_out_data", a_out_data, chan_a(0));
    check("drain_out_sel", a_out_sel, 0);

    // N=10 instance: s=9 grants, s>=N never grants
    b_mode = 1'b0; b_in_valid = 10'h3FF; b_out_ready = 1'b1; b_s = 4'd9;
    #1;
    check("b_s9_ready", b_in_ready, 10'h200);
    tick();
    check("b_s9_sel", b_out_sel, 9);
    check("b_s9_data", b_out_data, 8'h59);
    b_s = 4'd10;
    #1;
    check("b_s10_ready", b_in_ready, 0);
    tick();
    check("b_s10_valid", b_out_valid, 0);
    check("b_s10_sel", b_out_sel, 9);
    b_s = 4'd15;
    #1;
    check("b_s15_ready", b_in_ready, 0);

    // N=10 round-robin wrap 9 -> 0
    b_mode = 1'b1; b_in_valid = 10'b10_0000_0001;
    tick();
    check("b_rr_sel0", b_out_sel, 0);
    tick();
    check("b_rr_sel9", b_out_sel, 9);
    tick();
    check("b_rr_wrap", b_out_sel, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
